// File: rtl/press_edit_controller.sv
// Edit sequencer between the button press detectors and the alarm-clock registers.
// Walks time hours -> time minutes -> time commit -> alarm hours -> alarm minutes
// -> alarm commit. The selected field steps with wrap-around and auto-repeats while
// a long press is held. An edit that sits idle too long is abandoned without a load.
//
// state    | meaning
// ---------+------------------------------------------------------
// RUN      | normal display, plus/minus ignored
// T_HOUR   | editing time hours (blink hours)
// T_MIN    | editing time minutes (blink minutes)
// T_COMMIT | one cycle, time_load strobe, then alarm value is loaded
// A_HOUR   | editing alarm hours (blink hours)
// A_MIN    | editing alarm minutes (blink minutes)
// A_COMMIT | one cycle, alarm_load strobe, then back to RUN
module press_edit_controller #(
    parameter int REPEAT_MS  = 200,
    parameter int TIMEOUT_MS = 30000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_short_i,
    input  logic       plus_short_i,
    input  logic       plus_long_i,
    input  logic       minus_short_i,
    input  logic       minus_long_i,
    input  logic [4:0] cur_hour_i,
    input  logic [5:0] cur_min_i,
    input  logic [4:0] alm_hour_i,
    input  logic [5:0] alm_min_i,
    output logic [4:0] edit_hour_o,
    output logic [5:0] edit_min_o,
    output logic [2:0] mode_o,
    output logic       time_load_o,
    output logic       alarm_load_o,
    output logic [1:0] blink_field_o
);

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        T_HOUR   = 3'd1,
        T_MIN    = 3'd2,
        T_COMMIT = 3'd3,
        A_HOUR   = 3'd4,
        A_MIN    = 3'd5,
        A_COMMIT = 3'd6
    } state_t;

    localparam int RPT_W  = (REPEAT_MS > 2) ? $clog2(REPEAT_MS) : 1;
    localparam int IDLE_W = (TIMEOUT_MS > 2) ? $clog2(TIMEOUT_MS) : 1;
    localparam logic [RPT_W-1:0]  RPT_LOAD  = RPT_W'(REPEAT_MS - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_MS - 1);

    state_t            state_q, state_d;
    logic [4:0]        hour_q, hour_d;
    logic [5:0]        min_q, min_d;
    logic [RPT_W-1:0]  rpt_q, rpt_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              plus_long_q, minus_long_q;
    logic              time_load_q, time_load_d;
    logic              alarm_load_q, alarm_load_d;
    logic [1:0]        blink_q, blink_d;

    logic edit_st, hour_st, both_long, any_long, long_rise, long_fall;
    logic tick, inc_ev, dec_ev, activity, timeout;

    assign edit_st   = (state_q == T_HOUR) || (state_q == T_MIN) ||
                       (state_q == A_HOUR) || (state_q == A_MIN);
    assign hour_st   = (state_q == T_HOUR) || (state_q == A_HOUR);
    assign both_long = plus_long_i & minus_long_i;
    assign any_long  = plus_long_i | minus_long_i;
    assign long_rise = (plus_long_i & ~plus_long_q) | (minus_long_i & ~minus_long_q);
    assign long_fall = (~plus_long_i & plus_long_q) | (~minus_long_i & minus_long_q);
    // A cleared counter means the next held cycle ticks right away.
    assign tick      = ~both_long & (long_rise | (any_long & (rpt_q == '0)));
    assign inc_ev    = plus_short_i  | (tick & plus_long_i);
    assign dec_ev    = minus_short_i | (tick & minus_long_i);
    assign activity  = mode_short_i | plus_short_i | minus_short_i | any_long;
    assign timeout   = edit_st & ~activity & (idle_q == IDLE_LAST);

    // Next-state, field stepping, counters and registered output decode.
    always_comb begin
        state_d = state_q;
        hour_d  = hour_q;
        min_d   = min_q;
        case (state_q)
            RUN: begin
                if (mode_short_i) begin
                    hour_d  = cur_hour_i;
                    min_d   = cur_min_i;
                    state_d = T_HOUR;
                end
            end
            T_HOUR:   if (mode_short_i) state_d = T_MIN;
            T_MIN:    if (mode_short_i) state_d = T_COMMIT;
            T_COMMIT: begin
                hour_d  = alm_hour_i;
                min_d   = alm_min_i;
                state_d = A_HOUR;
            end
            A_HOUR:   if (mode_short_i) state_d = A_MIN;
            A_MIN:    if (mode_short_i) state_d = A_COMMIT;
            A_COMMIT: state_d = RUN;
            default:  state_d = RUN;
        endcase
        if (timeout) begin
            state_d = RUN;
        end

        // mode_short wins over a step; simultaneous inc and dec cancel.
        if (edit_st && !mode_short_i && (inc_ev != dec_ev)) begin
            if (hour_st) begin
                if (inc_ev) hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                else        hour_d = (hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1;
            end else begin
                if (inc_ev) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                else        min_d = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
            end
        end

        if (!edit_st || activity || timeout) idle_d = '0;
        else                                 idle_d = idle_q + IDLE_W'(1);

        if ((state_d != state_q) || both_long) rpt_d = '0;
        else if (tick)                         rpt_d = RPT_LOAD;
        else if (long_fall)                    rpt_d = '0;
        else if (rpt_q != '0)                  rpt_d = rpt_q - RPT_W'(1);
        else                                   rpt_d = rpt_q;

        time_load_d  = (state_d == T_COMMIT);
        alarm_load_d = (state_d == A_COMMIT);
        case (state_d)
            T_HOUR, A_HOUR: blink_d = 2'd1;
            T_MIN, A_MIN:   blink_d = 2'd2;
            default:        blink_d = 2'd0;
        endcase
    end

    // State, edit fields, counters and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            hour_q       <= '0;
            min_q        <= '0;
            rpt_q        <= '0;
            idle_q       <= '0;
            plus_long_q  <= 1'b0;
            minus_long_q <= 1'b0;
            time_load_q  <= 1'b0;
            alarm_load_q <= 1'b0;
            blink_q      <= 2'd0;
        end else begin
            state_q      <= state_d;
            hour_q       <= hour_d;
            min_q        <= min_d;
            rpt_q        <= rpt_d;
            idle_q       <= idle_d;
            plus_long_q  <= plus_long_i;
            minus_long_q <= minus_long_i;
            time_load_q  <= time_load_d;
            alarm_load_q <= alarm_load_d;
            blink_q      <= blink_d;
        end
    end

    assign edit_hour_o   = hour_q;
    assign edit_min_o    = min_q;
    assign mode_o        = state_q;
    assign time_load_o   = time_load_q;
    assign alarm_load_o  = alarm_load_q;
    assign blink_field_o = blink_q;

endmodule

// File: doc/press_edit_controller.md
# press_edit_controller

Sequencing controller between the button press detectors and the alarm-clock registers. It consumes the short-press pulses and long-press levels for the mode, plus and minus buttons, and walks an edit FSM through four fields in order: time hours, time minutes, alarm hours, alarm minutes. It steps the selected field with wrap-around, auto-repeats while plus or minus is held long, and arbitrates plus against minus. It commits the edited values to the timekeeper and alarm registers with one-cycle load strobes. The block runs on the 1 kHz system tick.

## Interface
- REPEAT_MS, 200: auto-repeat interval in clk cycles while a long press is held (≥2).
- TIMEOUT_MS, 30000: number of idle clk cycles in an edit state before the edit is abandoned (≥2).

- clk  in  1  1 kHz system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode_short  in  1  one-cycle pulse for a mode-button short press.
- plus_short  in  1  one-cycle pulse for a plus short press.
- plus_long  in  1  level; high while plus is held past the long-press threshold.
- minus_short  in  1  one-cycle pulse for a minus short press.
- minus_long  in  1  level; high while minus is held past the long-press threshold.
- cur_hour  in  5  running hour from the timekeeper (0–23).
- cur_min  in  6  running minute (0–59).
- alm_hour  in  5  stored alarm hour (0–23).
- alm_min  in  6  stored alarm minute (0–59).
- edit_hour  out  5  hour being edited; registered.
- edit_min  out  6  minute being edited; registered.
- mode  out  3  current FSM state encoding.
- time_load  out  1  one-cycle strobe; timekeeper loads edit_hour/edit_min.
- alarm_load  out  1  one-cycle strobe; alarm register loads edit_hour/edit_min.
- blink_field  out  2  display blink select: 0 none, 1 hours, 2 minutes.

## Operation
- States and encodings: RUN=0, T_HOUR=1, T_MIN=2, T_COMMIT=3, A_HOUR=4, A_MIN=5, A_COMMIT=6. Encoding 7 is illegal and recovers to RUN.
- RUN:
  - plus and minus inputs are ignored.
  - mode_short: edit_hour←cur_hour, edit_min←cur_min, go to T_HOUR.
- T_HOUR, then mode_short → T_MIN.
- T_MIN, then mode_short → T_COMMIT.
- T_COMMIT lasts one cycle:
  - time_load=1.
  - edit values stay unchanged for that cycle.
  - On exit, edit_hour←alm_hour and edit_min←alm_min, go to A_HOUR.
- A_HOUR, then mode_short → A_MIN.
- A_MIN, then mode_short → A_COMMIT.
- A_COMMIT lasts one cycle: alarm_load=1, then go to RUN.
- blink_field:
  - 1 in T_HOUR and A_HOUR.
  - 2 in T_MIN and A_MIN.
  - 0 otherwise.
- Steps in *_HOUR/*_MIN states:
  - An inc event adds 1 to the selected field.
  - A dec event subtracts 1.
  - Hours wrap 23↔0; minutes wrap 59↔0.
  - The unselected field is never touched.
- Inc event: plus_short pulse, or a plus auto-repeat tick. Dec event: minus_short pulse, or a minus auto-repeat tick.
- Auto-repeat:
  - On the rising edge of plus_long (or minus_long), fire one tick immediately.
  - Then fire one tick every REPEAT_MS cycles while the level stays high.
  - A single repeat counter is shared by both buttons.
  - The counter clears on a falling edge, on any state change, and whenever both long levels are high.
- Arbitration:
  - An inc event and a dec event in the same cycle cancel: no step.
  - plus_long and minus_long both high: no repeat ticks.
  - mode_short has priority over a step in the same cycle: the transition occurs and the step is dropped.
- Timeout:
  - The idle counter counts in edit states only.
  - It clears on any mode, plus or minus short pulse, and on any long level being high.
  - On reaching TIMEOUT_MS, go to RUN with no load strobe; the edits are discarded.
  - The counter clears on entry to RUN.
- Commit states ignore all inputs.

## Timing
- Reset values:
  - mode=RUN
  - edit_hour=0, edit_min=0
  - time_load=0, alarm_load=0
  - blink_field=0
  - repeat and idle counters=0
- Reset takes effect immediately (asynchronous). Reset during a commit state suppresses the strobe.
- All outputs are registered. An input sampled at edge n is reflected on outputs after edge n.
- Auto-repeat cadence: long level rises before edge n → steps after edges n, n+REPEAT_MS, n+2·REPEAT_MS, …
- Each load strobe is high for exactly one cycle. edit_* are stable during the strobe and equal the committed value.
- The strobes are never high simultaneously.
- Timeout fires on the TIMEOUT_MS-th consecutive idle edge.

## Test plan
- Edit and commit the time:
  - Stimulus: cur=13:59; mode_short; plus_short ×11; mode_short; minus_short ×60; mode_short.
  - Response: T_HOUR with edit 13:59; hour 0 after 11 incs; minute back at 59 after 60 decs; time_load for one cycle with edit=00:59; then mode=A_HOUR with edit=alarm value.
- Wrap:
  - Stimulus: in T_HOUR with edit_hour=0, one minus_short. In T_MIN with edit_min=59, one plus_short.
  - Response: edit_hour=23; edit_min=0.
- Auto-repeat (REPEAT_MS=200):
  - Stimulus: in A_MIN from 10, hold plus_long for 650 cycles.
  - Response: steps at cycles 0, 200, 400, 600; edit_min=14. Release, then re-raise: immediate step.
- Arbitration:
  - Stimulus: plus_short and minus_short in the same cycle; then both long levels high for 1000 cycles.
  - Response: no change in either case.
- Timeout (TIMEOUT_MS=50):
  - Stimulus: enter T_MIN and edit, then go idle for 50 cycles.
  - Response: mode=RUN, no time_load.
  - Stimulus: a pulse at idle cycle 49.
  - Response: the idle count restarts.
- Asynchronous reset:
  - Stimulus: rst asserted in T_COMMIT before the edge.
  - Response: no time_load; all outputs at reset values immediately.
